gray_updown_counter: RTL and testbench
======================================

# gray_updown_counter

Parametrised up/down counter that presents its value as binary and Gray code, always cycle-aligned. It supports count enable, direction select, and synchronous load of a Gray-coded value, and it flags wrap-around. It is the general-purpose replacement for the fixed 3-bit up-only Gray counter. It is intended for pointer generation in clock-crossing FIFOs and for position counters elsewhere in the design.

## Interface
- WIDTH, 4: counter width in bits; legal range 2..16.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 counts up, 0 counts down; sampled only when en=1.
- load  input  1  synchronous load strobe.
- load_gray  input  WIDTH  Gray-coded value to load; sampled when load=1.
- bin  output  WIDTH  registered binary count.
- gray  output  WIDTH  registered Gray count; always equals bin ^ (bin >> 1) in the same cycle.
- wrap  output  1  registered one-cycle pulse marking a wrap (or a saturation hit under the macro).

## Operation
- Single state register holds the binary count `cnt`.
- `bin` and `gray` are both registered from the same next-state value, so there is no skew between them.
- Priority, highest first: reset, then load, then en, then hold.
- reset:
  - `cnt`, `bin`, `gray` and `wrap` are all 0.
  - This holds regardless of en and load.
- load:
  - `cnt` takes gray2bin(load_gray).
  - `gray` takes load_gray exactly.
  - `wrap` is 0.
  - en and up are ignored in that cycle.
- en=1, up=1: `cnt` becomes cnt+1 modulo 2^WIDTH.
- en=1, up=0: `cnt` becomes cnt-1 modulo 2^WIDTH.
- en=0: hold; `wrap` is 0.
- Wrap condition:
  - Up step from 2^WIDTH-1 to 0, or down step from 0 to 2^WIDTH-1.
  - `wrap` is 1 in the cycle the new value appears, and 0 in every other cycle.
- Arithmetic is WIDTH bits, unsigned; any carry or borrow is discarded.
- Successive `gray` values produced by counting differ in exactly one bit, including at the wrap and on a direction reversal.
- A load may change any number of bits.
- A direction change takes effect on the same edge it is sampled; there is no dead cycle.

## Timing
- Latency is 1 cycle from sampled inputs (en, up, load, load_gray) to the updated bin, gray and wrap.
- There is no combinational path from any input to any output.
- A reset asserted mid-count takes effect at the next edge. The first step after reset deasserts (with en=1, up=1) yields bin=1.
- Continuous en=1 gives a full period of 2^WIDTH cycles between wrap pulses.

## Configuration
- GRAY_CNT_SAT_EN defined: saturating mode.
  - An up step at 2^WIDTH-1, or a down step at 0, holds the count.
  - `wrap` pulses for one cycle on each blocked step.
  - The count never wraps.
- GRAY_CNT_SAT_EN undefined: modulo wrap as described under Operation.
- Load and reset behaviour are identical in both modes.

## Structure
- Shared package `gray_cnt_pkg`:
  - Function bin2gray(x) = x ^ (x >> 1).
  - Constant WIDTH_MAX = 16.
- Sub-module `gray2bin`:
  - Combinational, parameter WIDTH.
  - Computes b[WIDTH-1] = g[WIDTH-1], then b[i] = b[i+1] ^ g[i].
  - Used on the load path and by the bench's checker.
- The top level holds the count register, the next-state mux and the wrap logic.

## Test plan
All scenarios use WIDTH=3.
- Reset, then 8 cycles with en=1, up=1:
  - bin goes 1,2,…,7,0.
  - gray goes 001,011,010,110,111,101,100,000.
  - wrap=1 only on the cycle bin returns to 0.
- After reset, en=1, up=0 for one cycle: bin=7, gray=100, wrap=1. A further 7 down steps reach bin=0 with no wrap.
- load=1, load_gray=110 with en=1 in the same cycle: next bin=4, gray=110, wrap=0. One up step then gives bin=5, gray=111.
- Count up to bin=5, then assert reset while en=1: next cycle bin=0, gray=0, wrap=0. Deassert reset: following cycle bin=1.
- Direction reversal every cycle over 20 random cycles: the checker confirms gray == bin2gray(bin) and a single-bit Hamming distance on every counted step.
- With GRAY_CNT_SAT_EN: 10 up steps from reset hold bin at 7, with wrap pulsing on each blocked step. Down steps from 0 hold bin at 0 with wrap=1.

Source files
------------

// File: rtl/gray_cnt_pkg.sv
// gray_cnt_pkg: shared definitions for the Gray up/down counter family.
// Holds the widest supported counter width, the step decode type and the
// binary-to-Gray helper used by the counter and its users.
package gray_cnt_pkg;

    localparam int WIDTH_MAX = 16;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_LOAD = 2'd3
    } step_e;

    function automatic logic [WIDTH_MAX-1:0] bin2gray(input logic [WIDTH_MAX-1:0] x);
        return x ^ (x >> 1);
    endfunction

endpackage

// File: rtl/gray_updown_counter_gray2bin.sv
// gray2bin: combinational Gray-to-binary converter.
// Each binary bit is the running XOR of all Gray bits from the MSB down to it.
module gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b
);

    logic [WIDTH-1:0] acc;

    // Ripple the XOR from the MSB toward the LSB
    always_comb begin
        acc = '0;
        acc[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            acc[i] = acc[i+1] ^ g[i];
        end
        b = acc;
    end

endmodule

// File: rtl/gray_updown_counter.sv
// gray_updown_counter: parametrised up/down counter presenting its value as
// cycle-aligned binary and Gray code, with synchronous Gray load and a
// one-cycle wrap pulse. Legal WIDTH range is 2..16.
// Optional macro GRAY_CNT_SAT_EN: the count saturates at its ends instead of
// wrapping, and the wrap output pulses on every blocked step.
module gray_updown_counter
    import gray_cnt_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    step_e            step;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] gray_next;
    logic [WIDTH-1:0] load_bin;
    logic             wrap_next;

    gray2bin #(
        .WIDTH(WIDTH)
    ) u_load_g2b (
        .g(load_gray),
        .b(load_bin)
    );

    // Decode the control inputs by priority: load beats count, count beats hold
    always_comb begin
        step = STEP_HOLD;
        if (load) begin
            step = STEP_LOAD;
        end else if (en) begin
            step = up ? STEP_UP : STEP_DOWN;
        end
    end

    // Next count, wrap flag and Gray image, all derived from one next-state value
    always_comb begin
        cnt_next  = cnt;
        wrap_next = 1'b0;
        case (step)
            STEP_LOAD: begin
                cnt_next = load_bin;
            end
            STEP_UP: begin
                wrap_next = (cnt == CNT_MAX);
`ifdef GRAY_CNT_SAT_EN
                if (cnt != CNT_MAX) begin
                    cnt_next = cnt + CNT_ONE;
                end
`else
                cnt_next = cnt + CNT_ONE;
`endif
            end
            STEP_DOWN: begin
                wrap_next = (cnt == '0);
`ifdef GRAY_CNT_SAT_EN
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_ONE;
                end
`else
                cnt_next = cnt - CNT_ONE;
`endif
            end
            default: begin
                cnt_next = cnt;
            end
        endcase
        if (step == STEP_LOAD) begin
            gray_next = load_gray;
        end else begin
            gray_next = WIDTH'(bin2gray(WIDTH_MAX'(cnt_next)));
        end
    end

    // Register count, Gray and wrap together so the outputs never skew
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            gray <= gray_next;
            wrap <= wrap_next;
        end
    end

    assign bin = cnt;

endmodule

// File: tb/tb_gray_updown_counter.sv
// tb_gray_updown_counter: self-checking bench for gray_updown_counter, WIDTH=3.
// Expectations are queued as stimulus is driven and popped after each edge.
// Build with GRAY_CNT_SAT_EN defined to exercise the saturating variant.
module tb_gray_updown_counter;

    localparam int W = 3;

    typedef struct {
        logic [W-1:0] bin;
        logic [W-1:0] gray;
        logic         wrap;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_gray = '0;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;
    int   m_cnt = 0;

    gray_updown_counter #(
        .WIDTH(W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .up(up),
        .load(load),
        .load_gray(load_gray),
        .bin(bin),
        .gray(gray),
        .wrap(wrap)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    function automatic logic [W-1:0] tb_gray(input int b);
        logic [W-1:0] v;
        v = W'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [W-1:0] tb_g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        for (int i = 0; i < W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // Reference model: advances m_cnt and returns the expected registered outputs
    function automatic exp_t model_step(input logic r, input logic e, input logic u,
                                        input logic l, input logic [W-1:0] lg,
                                        input string nm);
        exp_t x;
        x.name = nm;
        x.wrap = 1'b0;
        if (r) begin
            m_cnt = 0;
        end else if (l) begin
            m_cnt = int'(tb_g2b(lg));
        end else if (e) begin
            if (u) begin
                if (m_cnt == (1 << W) - 1) begin
                    x.wrap = 1'b1;
`ifdef GRAY_CNT_SAT_EN
`else
                    m_cnt = 0;
`endif
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                if (m_cnt == 0) begin
                    x.wrap = 1'b1;
`ifdef GRAY_CNT_SAT_EN
`else
                    m_cnt = (1 << W) - 1;
`endif
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end
        x.bin  = W'(m_cnt);
        x.gray = (l && !r) ? lg : tb_gray(m_cnt);
        return x;
    endfunction

    function automatic exp_t mk(input int b, input logic w, input string nm);
        exp_t x;
        x.bin  = W'(b);
        x.gray = tb_gray(b);
        x.wrap = w;
        x.name = nm;
        return x;
    endfunction

    task automatic applyStimulus(input logic r, input logic e, input logic u,
                                 input logic l, input logic [W-1:0] lg);
        reset     = r;
        en        = e;
        up        = u;
        load      = l;
        load_gray = lg;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t x;
        sb.push_back(mk(0, 1'b0, "reset_with_en_load"));
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'b101);
        x = sb.pop_front();
        total++;
        if (bin !== x.bin || gray !== x.gray || wrap !== x.wrap)
            $display("[TB] FAIL %s: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                     x.name, bin, gray, wrap, x.bin, x.gray, x.wrap);
        else passed++;
    endtask

`ifndef GRAY_CNT_SAT_EN
    task automatic test_count_up();
        exp_t x;
        logic [W-1:0] gtab [8];
        gtab = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) begin
            x.bin  = W'((i + 1) % 8);
            x.gray = gtab[i];
            x.wrap = (i == 7);
            x.name = $sformatf("count_up_%0d", i);
            sb.push_back(x);
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
            x = sb.pop_front();
            total++;
            if (bin !== x.bin || gray !== x.gray || wrap !== x.wrap)
                $display("[TB] FAIL %s: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                         x.name, bin, gray, wrap, x.bin, x.gray, x.wrap);
            else passed++;
        end
    endtask

    task automatic test_count_down();
        exp_t x;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) begin
            x = mk(7 - i, (i == 0), $sformatf("count_down_%0d", i));
            if (i == 0 && x.gray !== 3'b100) $display("[TB] bench table error");
            sb.push_back(x);
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
            x = sb.pop_front();
            total++;
            if (bin !== x.bin || gray !== x.gray || wrap !== x.wrap)
                $display("[TB] FAIL %s: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                         x.name, bin, gray, wrap, x.bin, x.gray, x.wrap);
            else passed++;
        end
    endtask

    task automatic test_full_period();
        int wraps = 0;
        int first = -1;
        int gap = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
            if (wrap === 1'b1) begin
                if (first < 0) first = i;
                else gap = i - first;
                wraps++;
            end
        end
        total++;
        if (wraps != 2 || gap != 8)
            $display("[TB] FAIL full_period: got %0d wraps gap %0d, want 2 wraps gap 8", wraps, gap);
        else passed++;
    endtask
`else
    task automatic test_saturate();
        exp_t x;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 1; i <= 10; i++) begin
            sb.push_back(mk((i > 7) ? 7 : i, (i > 7), $sformatf("sat_up_%0d", i)));
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
            x = sb.pop_front();
            total++;
            if (bin !== x.bin || gray !== x.gray || wrap !== x.wrap)
                $display("[TB] FAIL %s: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                         x.name, bin, gray, wrap, x.bin, x.gray, x.wrap);
            else passed++;
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(0, 1'b1, $sformatf("sat_down_%0d", i)));
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
            x = sb.pop_front();
            total++;
            if (bin !== x.bin || gray !== x.gray || wrap !== x.wrap)
                $display("[TB] FAIL %s: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                         x.name, bin, gray, wrap, x.bin, x.gray, x.wrap);
            else passed++;
        end
    endtask
`endif

    task automatic test_load();
        exp_t x;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        x.bin = 3'd4; x.gray = 3'b110; x.wrap = 1'b0; x.name = "load_110";
        sb.push_back(x);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 3'b110);
        x = sb.pop_front();
        total++;
        if (bin !== x.bin || gray !== x.gray || wrap !== x.wrap)
            $display("[TB] FAIL %s: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                     x.name, bin, gray, wrap, x.bin, x.gray, x.wrap);
        else passed++;
        x.bin = 3'd5; x.gray = 3'b111; x.wrap = 1'b0; x.name = "up_after_load";
        sb.push_back(x);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
        x = sb.pop_front();
        total++;
        if (bin !== x.bin || gray !== x.gray || wrap !== x.wrap)
            $display("[TB] FAIL %s: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                     x.name, bin, gray, wrap, x.bin, x.gray, x.wrap);
        else passed++;
    endtask

    task automatic test_load_hold();
        exp_t x;
        logic [W-1:0] lg;
        sb.push_back(model_step(1'b1, 1'b0, 1'b0, 1'b0, '0, "lh_reset"));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        void'(sb.pop_front());
        for (int i = 0; i < 6; i++) begin
            lg = (i == 0) ? 3'b100 : W'($urandom_range(0, 7));
            sb.push_back(model_step(1'b0, 1'b1, 1'b1, 1'b1, lg, $sformatf("load_rand_%0d", i)));
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, lg);
            x = sb.pop_front();
            total++;
            if (bin !== x.bin || gray !== x.gray || wrap !== x.wrap)
                $display("[TB] FAIL %s: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                         x.name, bin, gray, wrap, x.bin, x.gray, x.wrap);
            else passed++;
            sb.push_back(model_step(1'b0, 1'b0, i[0], 1'b0, '0, $sformatf("hold_%0d", i)));
            applyStimulus(1'b0, 1'b0, i[0], 1'b0, '0);
            x = sb.pop_front();
            total++;
            if (bin !== x.bin || gray !== x.gray || wrap !== x.wrap)
                $display("[TB] FAIL %s: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                         x.name, bin, gray, wrap, x.bin, x.gray, x.wrap);
            else passed++;
        end
    endtask

    task automatic test_reset_midcount();
        exp_t x;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
        total++;
        if (bin !== 3'd5)
            $display("[TB] FAIL pre_reset_count: got bin=%0d, want bin=5", bin);
        else passed++;
        sb.push_back(mk(0, 1'b0, "mid_reset"));
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
        x = sb.pop_front();
        total++;
        if (bin !== x.bin || gray !== x.gray || wrap !== x.wrap)
            $display("[TB] FAIL %s: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                     x.name, bin, gray, wrap, x.bin, x.gray, x.wrap);
        else passed++;
        sb.push_back(mk(1, 1'b0, "first_after_reset"));
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
        x = sb.pop_front();
        total++;
        if (bin !== x.bin || gray !== x.gray || wrap !== x.wrap)
            $display("[TB] FAIL %s: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                     x.name, bin, gray, wrap, x.bin, x.gray, x.wrap);
        else passed++;
    endtask

    task automatic test_back_to_back_reversal();
        exp_t x;
        logic [W-1:0] prev_gray;
        logic         e;
        logic         u;
        logic         moved;
        sb.push_back(model_step(1'b1, 1'b0, 1'b0, 1'b0, '0, "rev_reset"));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        void'(sb.pop_front());
        prev_gray = 3'b000;
        u = 1'($urandom_range(0, 1));
        for (int i = 0; i < 20; i++) begin
            u = ~u;
            e = ($urandom_range(0, 7) != 0);
            sb.push_back(model_step(1'b0, e, u, 1'b0, '0, $sformatf("reversal_%0d", i)));
            applyStimulus(1'b0, e, u, 1'b0, '0);
            x = sb.pop_front();
            total++;
            if (bin !== x.bin || gray !== x.gray || wrap !== x.wrap)
                $display("[TB] FAIL %s: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                         x.name, bin, gray, wrap, x.bin, x.gray, x.wrap);
            else passed++;
            moved = (x.gray !== prev_gray);
            if (e && moved) begin
                total++;
                if ($countones(gray ^ prev_gray) != 1)
                    $display("[TB] FAIL hamming_%0d: got distance %0d, want 1",
                             i, $countones(gray ^ prev_gray));
                else passed++;
            end
            prev_gray = gray;
        end
    endtask

    // Run every scenario in sequence, then report
    initial begin
        test_reset();
`ifndef GRAY_CNT_SAT_EN
        test_count_up();
        test_count_down();
        test_full_period();
`else
        test_saturate();
`endif
        test_load();
        test_load_hold();
        test_reset_midcount();
        test_back_to_back_reversal();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
